// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving the I-cache and the D-cache
// alternating access to one shared memory port. The granted request is
// registered onto the memory bus. Completion is routed back to the granted
// client in the same cycle as mem_ready.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   // I-cache side
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   // D-cache side
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   // shared memory port
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;          // 0 = I granted last, 1 = D
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                d_req;
   logic                grant_d;
   logic                busy;

   // D wins when it is alone, or on a tie when I was served last.
   assign d_req   = d_read | d_write;
   assign grant_d = d_req & (~i_read | ~last_q);
   assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);

   // Read data is broadcast; only the ready pulse qualifies it.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // Completion is steered to the owner of the transfer in the mem_ready cycle.
   assign i_ready = (state_q == BUSY_I) & mem_ready;
   assign d_ready = (state_q == BUSY_D) & mem_ready;

   // Request strobes fall in the completion cycle itself, not one cycle later.
   assign mem_read  = mem_read_q  & ~(busy & mem_ready);
   assign mem_write = mem_write_q & ~(busy & mem_ready);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Next-state logic: grant in IDLE, hold the bus while busy, clear on completion.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = BUSY_D;
               last_d      = 1'b1;
               // A write-back takes precedence over a read from the same cache.
               mem_write_d = d_write;
               mem_read_d  = ~d_write;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_write ? d_wdata : '0;
            end else if (i_read) begin
               state_d     = BUSY_I;
               last_d      = 1'b0;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
         end
      endcase
   end

   // State and memory-bus registers; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single I read, D write-back, reset tie,
// round-robin saturation, read+write collision and reset mid-transfer.
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;

   logic              clk;
   logic              rst_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   int n_cmp;
   int n_bad;

   localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [DATA_W-1:0] PAT_WB = 128'h0123456789ABCDEF0123456789ABCDEF;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_read    (i_read),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, ".mem_read"},  mem_read,  0);
      check_eq({tag, ".mem_write"}, mem_write, 0);
      check_eq({tag, ".mem_addr"},  mem_addr,  0);
      check_eq({tag, ".mem_wdata"}, mem_wdata, 0);
      check_eq({tag, ".i_ready"},   i_ready,   0);
      check_eq({tag, ".d_ready"},   d_ready,   0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Requests must already be driven. Grants on the next edge, holds for
   // `lat` extra cycles, then completes with mem_ready at the edge after.
   task automatic do_txn(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [ADDR_W-1:0] exp_addr,
                         input logic [DATA_W-1:0] exp_wdata,
                         input logic [DATA_W-1:0] rdata, input int lat);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, ".mem_read"},  mem_read,  !exp_wr);
      check_eq({tag, ".mem_write"}, mem_write, exp_wr);
      check_eq({tag, ".mem_addr"},  mem_addr,  exp_addr);
      check_eq({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         check_eq({tag, ".hold_addr"}, mem_addr, exp_addr);
         check_eq({tag, ".hold_rdy"},  {i_ready, d_ready}, 0);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      #1;
      check_eq({tag, ".i_ready"}, i_ready, !exp_d);
      check_eq({tag, ".d_ready"}, d_ready, exp_d);
      check_eq({tag, ".rdata"}, exp_d ? d_rdata : i_rdata, rdata);
      check_eq({tag, ".strobe_drop"}, {mem_read, mem_write}, 0);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      i_read = 0; i_addr = '0;
      d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      #1;
      check_idle_outputs("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single I read, 3 cycles of memory latency.
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000123;
      do_txn("i_read", 0, 0, 28'h0000123, '0, PAT_A5, 2);
      i_read = 0;
      @(negedge clk);
      check_idle_outputs("i_read.after");
      $display("txn i_read addr=0000123 done");

      // D write-back, held until mem_ready.
      d_write = 1; d_addr = 28'h00000F8; d_wdata = PAT_WB;
      do_txn("d_wb", 1, 1, 28'h00000F8, PAT_WB, '0, 3);
      d_write = 0;
      @(negedge clk);
      check_idle_outputs("d_wb.after");
      $display("txn d_write addr=00000F8 done");

      // Tie right after reset: D first, then I.
      do_reset();
      i_read = 1; i_addr = 28'h0000111;
      d_read = 1; d_addr = 28'h0000222;
      do_txn("tie.d", 1, 0, 28'h0000222, '0, 128'h1, 1);
      d_read = 0;
      do_txn("tie.i", 0, 0, 28'h0000111, '0, 128'h2, 1);
      $display("txn tie order D,I done");

      // Saturation: last = I, so D, I, D, I, D, I.
      d_read = 1;
      for (int t = 0; t < 6; t++) begin
         if (t % 2 == 0)
            do_txn("rr.d", 1, 0, 28'h0000222, '0, 128'h10 + 128'(t), t % 3);
         else
            do_txn("rr.i", 0, 0, 28'h0000111, '0, 128'h10 + 128'(t), t % 3);
         $display("txn rr %0d done", t);
      end
      i_read = 0; d_read = 0;
      @(negedge clk);

      // Read and write together: write wins.
      d_read = 1; d_write = 1; d_addr = 28'h0000ABC; d_wdata = PAT_A5;
      do_txn("rw", 1, 1, 28'h0000ABC, PAT_A5, '0, 0);
      d_read = 0; d_write = 0;
      @(negedge clk);
      $display("txn d_read+d_write -> write done");

      // Reset while BUSY_I.
      i_read = 1; i_addr = 28'h0000555;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_mid.mem_read", mem_read, 1);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_idle_outputs("rst_mid");
      i_read = 0;
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n = 1'b1;
      // Spurious mem_ready in IDLE.
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check_eq("spur.ready", {i_ready, d_ready}, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      check_idle_outputs("spur.after");
      $display("txn reset mid-transfer done");

      // Fresh I read after recovery.
      i_read = 1; i_addr = 28'h0000777;
      do_txn("post_rst", 0, 0, 28'h0000777, '0, PAT_A5, 1);
      i_read = 0;
      @(negedge clk);
      check_idle_outputs("post_rst.after");
      $display("txn post-reset i_read done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
